ccd_cds_sampler: RTL and testbench

Digital correlated-double-sampling controller sitting directly downstream of the `digital_cs` CCD clock sequencer. It watches the sequencer's `phi_r` (reset gate) and `phi_l2` (last horizontal phase, dumps charge onto the sense node) outputs. It times two ADC conversions per pixel, reference level then signal level, and emits the difference as a pixel word with a column index and end-of-line marker. All inputs come from the same `clk` domain as the sequencer, so no synchronisers are needed.

---
 rtl/ccd_pkg.sv | 18 +
 rtl/ccd_fall_det.sv | 19 +
 rtl/ccd_cds_sampler.sv | 185 ++++++++++++++++++
 tb/tb_ccd_cds_sampler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// Shared types for the CCD correlated-double-sampling chain: the sampler FSM
// state encoding and the pixel word passed on to the downstream line buffers.
package ccd_pkg;

    localparam int ADC_W_DEF = 12;

    typedef logic [ADC_W_DEF-1:0] pix_word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REF_WAIT = 3'd1,
        ST_REF_CONV = 3'd2,
        ST_SIG_ARM  = 3'd3,
        ST_SIG_WAIT = 3'd4,
        ST_SIG_CONV = 3'd5
    } cds_state_e;

endpackage

// File: rtl/ccd_fall_det.sv
// Registered falling-edge detector: fall_o is high in the cycle where d_i is 0
// and was 1 in the previous cycle.
module ccd_fall_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic fall_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_i;
    end

    assign fall_o = d_q & ~d_i;

endmodule

// File: rtl/ccd_cds_sampler.sv
// CDS controller: times reference and signal ADC conversions off the sequencer's
// phi_r / phi_l2 falling edges and emits a saturated (ref - sig) pixel word.
module ccd_cds_sampler
    import ccd_pkg::*;
#(
    parameter int ADC_W   = ADC_W_DEF,
    parameter int DLY_W   = 4,
    parameter int REF_DLY = 2,
    parameter int SIG_DLY = 2,
    parameter int NCOL    = 16,
    localparam int COL_W  = $clog2(NCOL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             phi_r,
    input  logic             phi_l2,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic             pix_valid,
    output logic [ADC_W-1:0] pix_data,
    output logic [COL_W-1:0] pix_col,
    output logic             line_end,
    output logic             overrun
);

    // adc_start is registered, so the counter holds delay-1 to land the pulse
    // exactly DLY+1 cycles after the edge; a zero delay skips the wait state.
    localparam logic [DLY_W-1:0] REF_LD   = DLY_W'((REF_DLY > 0) ? REF_DLY - 1 : 0);
    localparam logic [DLY_W-1:0] SIG_LD   = DLY_W'((SIG_DLY > 0) ? SIG_DLY - 1 : 0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOL - 1);

    logic r_fall, l2_fall;

    ccd_fall_det u_det_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (phi_r),
        .fall_o (r_fall)
    );

    ccd_fall_det u_det_l2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (phi_l2),
        .fall_o (l2_fall)
    );

    cds_state_e       state_q, state_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0] ref_q, ref_d;
    logic [ADC_W-1:0] pdata_q, pdata_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             start_q, start_d;
    logic             pv_q, pv_d;
    logic             le_q, le_d;
    logic             ovr_q, ovr_d;
    logic             go_ref, go_sig;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        pdata_d = pdata_q;
        col_d   = col_q;
        ovr_d   = ovr_q;
        start_d = 1'b0;
        pv_d    = 1'b0;
        le_d    = 1'b0;
        go_ref  = 1'b0;
        go_sig  = 1'b0;

        if (pv_q) col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

        if (!enable) begin
            state_d = ST_IDLE;
            col_d   = '0;
            ovr_d   = 1'b0;
            ref_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: go_ref = r_fall;
                ST_REF_WAIT: begin
                    if (r_fall) go_ref = 1'b1;
                    else if (l2_fall) begin
                        ovr_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = ST_REF_CONV;
                        start_d = 1'b1;
                    end else cnt_d = cnt_q - 1'b1;
                end
                ST_REF_CONV: begin
                    if (r_fall) go_ref = 1'b1;
                    else if (l2_fall) begin
                        ovr_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (adc_done) begin
                        ref_d   = adc_data;
                        state_d = ST_SIG_ARM;
                    end
                end
                ST_SIG_ARM: begin
                    if (r_fall) begin
                        ovr_d  = 1'b1;
                        go_ref = 1'b1;
                    end else go_sig = l2_fall;
                end
                ST_SIG_WAIT: begin
                    if (r_fall) begin
                        ovr_d  = 1'b1;
                        go_ref = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_SIG_CONV;
                        start_d = 1'b1;
                    end else cnt_d = cnt_q - 1'b1;
                end
                ST_SIG_CONV: begin
                    if (r_fall) begin
                        ovr_d  = 1'b1;
                        go_ref = 1'b1;
                    end else if (adc_done) begin
                        // video swings below reference: clamp at zero, never wrap
                        pv_d    = 1'b1;
                        pdata_d = (ref_q > adc_data) ? ref_q - adc_data : '0;
                        le_d    = (col_q == COL_LAST);
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (go_ref) begin
                if (REF_DLY == 0) begin
                    state_d = ST_REF_CONV;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_REF_WAIT;
                    cnt_d   = REF_LD;
                end
            end else if (go_sig) begin
                if (SIG_DLY == 0) begin
                    state_d = ST_SIG_CONV;
                    start_d = 1'b1;
                end else begin
                    state_d = ST_SIG_WAIT;
                    cnt_d   = SIG_LD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            pdata_q <= '0;
            col_q   <= '0;
            start_q <= 1'b0;
            pv_q    <= 1'b0;
            le_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            pdata_q <= pdata_d;
            col_q   <= col_d;
            start_q <= start_d;
            pv_q    <= pv_d;
            le_q    <= le_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_start = start_q;
    assign pix_valid = pv_q;
    assign pix_data  = pdata_q;
    assign pix_col   = col_q;
    assign line_end  = le_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_ccd_cds_sampler.sv
// Directed bench for ccd_cds_sampler: the sequencer and ADC are driven by hand
// and each scenario task compares outputs against hand-computed values.
module tb_ccd_cds_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        phi_r = 1'b0;
    logic        phi_l2 = 1'b0;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = '0;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic [3:0]  pix_col;
    logic        line_end;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int          pv_cnt, st_cnt, exp_col;
    logic [11:0] pv_data;
    logic [3:0]  pv_col;
    logic        pv_le;

    ccd_cds_sampler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .phi_r     (phi_r),
        .phi_l2    (phi_l2),
        .adc_start (adc_start),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_col   (pix_col),
        .line_end  (line_end),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // advance one cycle and record any strobes seen
    task automatic tick();
        @(posedge clk);
        #1;
        if (pix_valid) begin
            pv_cnt++;
            pv_data = pix_data;
            pv_col  = pix_col;
            pv_le   = line_end;
        end
        if (adc_start) st_cnt++;
    endtask

    // one full pixel with a responsive ADC; returns edge-to-start latencies
    task automatic run_pixel(input logic [11:0] refv, input logic [11:0] sigv,
                             output int lat_r, output int lat_s);
        pv_cnt = 0; st_cnt = 0; lat_r = -1; lat_s = -1;
        phi_r = 1'b1; tick(); phi_r = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (adc_start) begin lat_r = i; break; end
        end
        adc_done = 1'b1; adc_data = refv; tick(); adc_done = 1'b0; phi_r = 1'b1;
        phi_l2 = 1'b1; tick(); phi_l2 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (adc_start) begin lat_s = i; break; end
        end
        adc_done = 1'b1; adc_data = sigv; tick(); adc_done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL reset_adc_start: got %b expected 0", adc_start); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b expected 0", pix_valid); end
        checks++; if (pix_data !== 12'd0) begin errors++; $display("FAIL reset_pix_data: got %0d expected 0", pix_data); end
        checks++; if (pix_col !== 4'd0) begin errors++; $display("FAIL reset_pix_col: got %0d expected 0", pix_col); end
        checks++; if (line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end: got %b expected 0", line_end); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        tick();
        exp_col = 0;
    endtask

    task automatic test_normal();
        int lr, ls;
        run_pixel(12'd3000, 12'd1000, lr, ls);
        checks++; if (lr != 3) begin errors++; $display("FAIL normal_ref_latency: got %0d expected 3", lr); end
        checks++; if (ls != 3) begin errors++; $display("FAIL normal_sig_latency: got %0d expected 3", ls); end
        checks++; if (st_cnt != 2) begin errors++; $display("FAIL normal_start_count: got %0d expected 2", st_cnt); end
        checks++; if (pv_cnt != 1) begin errors++; $display("FAIL normal_valid_count: got %0d expected 1", pv_cnt); end
        checks++; if (pv_data !== 12'd2000) begin errors++; $display("FAIL normal_data: got %0d expected 2000", pv_data); end
        checks++; if (pv_col !== 4'd0) begin errors++; $display("FAIL normal_col: got %0d expected 0", pv_col); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL normal_overrun: got %b expected 0", overrun); end
        checks++; if (pix_col !== 4'd1) begin errors++; $display("FAIL normal_col_advance: got %0d expected 1", pix_col); end
        exp_col = 1;
    endtask

    task automatic test_saturation();
        int lr, ls;
        run_pixel(12'd500, 12'd800, lr, ls);
        checks++; if (pv_cnt != 1) begin errors++; $display("FAIL sat_valid_count: got %0d expected 1", pv_cnt); end
        checks++; if (pv_data !== 12'd0) begin errors++; $display("FAIL sat_data: got %0d expected 0", pv_data); end
        checks++; if (pv_col !== 4'd1) begin errors++; $display("FAIL sat_col: got %0d expected 1", pv_col); end
        run_pixel(12'd700, 12'd700, lr, ls);
        checks++; if (pv_data !== 12'd0) begin errors++; $display("FAIL sat_equal_data: got %0d expected 0", pv_data); end
        run_pixel(12'd701, 12'd700, lr, ls);
        checks++; if (pv_data !== 12'd1) begin errors++; $display("FAIL sat_one_data: got %0d expected 1", pv_data); end
        checks++; if (pv_col !== 4'd3) begin errors++; $display("FAIL sat_col3: got %0d expected 3", pv_col); end
        exp_col = 4;
    endtask

    task automatic test_overrun();
        int lr, ls;
        pv_cnt = 0; st_cnt = 0;
        phi_r = 1'b1; tick(); phi_r = 1'b0;
        repeat (3) tick();
        checks++; if (adc_start !== 1'b1) begin errors++; $display("FAIL ovr_ref_start: got %b expected 1", adc_start); end
        phi_l2 = 1'b1; tick(); phi_l2 = 1'b0; tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        adc_done = 1'b1; adc_data = 12'd100; tick(); adc_done = 1'b0;
        repeat (4) tick();
        checks++; if (pv_cnt != 0) begin errors++; $display("FAIL ovr_no_pixel: got %0d pixels expected 0", pv_cnt); end
        checks++; if (pix_col !== 4'd4) begin errors++; $display("FAIL ovr_col_hold: got %0d expected 4", pix_col); end
        run_pixel(12'd2000, 12'd500, lr, ls);
        checks++; if (pv_col !== 4'd4) begin errors++; $display("FAIL ovr_next_col: got %0d expected 4", pv_col); end
        checks++; if (pv_data !== 12'd1500) begin errors++; $display("FAIL ovr_next_data: got %0d expected 1500", pv_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        exp_col = 5;
    endtask

    task automatic test_enable_drop();
        int lr, ls;
        phi_r = 1'b1; tick(); phi_r = 1'b0;
        repeat (3) tick();
        adc_done = 1'b1; adc_data = 12'd3000; tick(); adc_done = 1'b0; phi_r = 1'b1;
        phi_l2 = 1'b1; tick(); phi_l2 = 1'b0;
        repeat (3) tick();
        checks++; if (adc_start !== 1'b1) begin errors++; $display("FAIL en_sig_start: got %b expected 1", adc_start); end
        pv_cnt = 0; st_cnt = 0;
        enable = 1'b0; adc_done = 1'b1; adc_data = 12'd1000; tick(); adc_done = 1'b0;
        repeat (9) tick();
        checks++; if (pv_cnt != 0) begin errors++; $display("FAIL en_no_pixel: got %0d pixels expected 0", pv_cnt); end
        checks++; if (pix_col !== 4'd0) begin errors++; $display("FAIL en_col_clear: got %0d expected 0", pix_col); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL en_ovr_clear: got %b expected 0", overrun); end
        checks++; if (st_cnt != 0) begin errors++; $display("FAIL en_no_start: got %0d expected 0", st_cnt); end
        enable = 1'b1; tick();
        run_pixel(12'd3000, 12'd1000, lr, ls);
        checks++; if (lr != 3) begin errors++; $display("FAIL en_resume_latency: got %0d expected 3", lr); end
        checks++; if (pv_cnt != 1 || pv_data !== 12'd2000) begin errors++; $display("FAIL en_resume_pixel: got %0d pixels data %0d expected 1 pixel data 2000", pv_cnt, pv_data); end
        checks++; if (pv_col !== 4'd0) begin errors++; $display("FAIL en_resume_col: got %0d expected 0", pv_col); end
        exp_col = 1;
    endtask

    task automatic test_full_line();
        int lr, ls;
        logic [11:0] rv, sv, ev;
        for (int i = 0; i < 17; i++) begin
            rv = 12'(1000 + 37 * i);
            sv = 12'(50 * i);
            ev = rv - sv;
            run_pixel(rv, sv, lr, ls);
            checks++; if (pv_cnt != 1 || pv_col !== 4'(exp_col) || pv_data !== ev) begin
                errors++;
                $display("FAIL line_pixel%0d: got n=%0d col=%0d data=%0d expected n=1 col=%0d data=%0d", i, pv_cnt, pv_col, pv_data, exp_col, ev);
            end
            checks++; if (pv_le !== (exp_col == 15)) begin
                errors++;
                $display("FAIL line_end%0d: got %b expected %b", i, pv_le, (exp_col == 15));
            end
            exp_col = (exp_col + 1) % 16;
        end
    endtask

    task automatic test_reset_mid();
        int lr, ls;
        phi_r = 1'b1; tick(); phi_r = 1'b0;
        repeat (3) tick();
        adc_done = 1'b1; adc_data = 12'd3000; tick(); adc_done = 1'b0; phi_r = 1'b1;
        phi_l2 = 1'b1; tick(); phi_l2 = 1'b0; tick();
        checks++; if (pix_col !== 4'(exp_col)) begin errors++; $display("FAIL rmid_pre_col: got %0d expected %0d", pix_col, exp_col); end
        rst_n = 1'b0;
        #2;
        checks++; if (pix_col !== 4'd0 || adc_start !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 12'd0 || line_end !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outputs: got col=%0d start=%b valid=%b data=%0d le=%b ovr=%b expected all 0", pix_col, adc_start, pix_valid, pix_data, line_end, overrun);
        end
        tick(); tick();
        rst_n = 1'b1;
        pv_cnt = 0; st_cnt = 0;
        adc_done = 1'b1; adc_data = 12'd5; tick(); adc_done = 1'b0;
        repeat (8) tick();
        checks++; if (st_cnt != 0 || pv_cnt != 0) begin errors++; $display("FAIL rmid_quiet: got starts=%0d pixels=%0d expected 0 and 0", st_cnt, pv_cnt); end
        run_pixel(12'd1234, 12'd234, lr, ls);
        checks++; if (lr != 3 || pv_cnt != 1 || pv_data !== 12'd1000 || pv_col !== 4'd0) begin
            errors++;
            $display("FAIL rmid_resume: got lat=%0d n=%0d data=%0d col=%0d expected 3 1 1000 0", lr, pv_cnt, pv_data, pv_col);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_saturation();
        test_overrun();
        test_enable_drop();
        test_full_line();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
